// File: rtl/bvh_update_engine_if.sv
// Node-memory bus between the BVH update engine (master) and node storage (slave).
// Reads are in-order with one response per accepted request; writes are valid/ready.
interface bvh_update_engine_if #(
    parameter int ADDR_W  = 13,
    parameter int COORD_W = 16
);
    logic                   rd_req;
    logic [ADDR_W-1:0]      rd_addr;
    logic                   rd_ready;
    logic                   rd_valid;
    logic [6*COORD_W-1:0]   rd_data;
    logic                   wr_valid;
    logic [ADDR_W-1:0]      wr_addr;
    logic [6*COORD_W-1:0]   wr_data;
    logic                   wr_ready;

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, rd_valid, rd_data, wr_ready
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, rd_valid, rd_data, wr_ready
    );
endinterface

// File: rtl/bvh_update_engine.sv
// BVH maintenance engine: optional builder handoff followed by a bottom-up refit
// of internal-node bounds over an implicit complete binary tree.
module bvh_update_engine #(
    parameter int NODE_W  = 12,
    parameter int ADDR_W  = 13,
    parameter int COORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_rebuild,
    input  logic              start_refit,
    input  logic [NODE_W-1:0] num_internal,
    output logic              build_req,
    input  logic              build_ack,
    input  logic              build_done,
    bvh_update_engine_if.master mem,
    output logic              busy,
    output logic              done,
    output logic              job_was_rebuild,
    output logic [NODE_W-1:0] nodes_refit
);
    localparam int BW = 6 * COORD_W;

    typedef enum logic [3:0] {
        IDLE, BREQ, BWAIT, RINIT, RDL, WTL, RDR, WTR, WR, DONE
    } state_t;

    state_t            state;
    logic              mode_rebuild;
    logic              pend_rebuild;
    logic              pend_refit;
    logic [NODE_W-1:0] idx;
    logic [NODE_W-1:0] cnt;
    logic [BW-1:0]     left;
    logic [NODE_W-1:0] idx_m1;
    logic [NODE_W-1:0] n_m1;

    assign idx_m1 = idx - NODE_W'(1);
    assign n_m1   = num_internal - NODE_W'(1);

    // Components 0..2 are minima, 3..5 maxima; all compared as signed values.
    function automatic logic [BW-1:0] merge(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            logic signed [COORD_W-1:0] ca;
            logic signed [COORD_W-1:0] cb;
            ca = $signed(a[k*COORD_W +: COORD_W]);
            cb = $signed(b[k*COORD_W +: COORD_W]);
            if (k < 3) m[k*COORD_W +: COORD_W] = (ca < cb) ? ca : cb;
            else       m[k*COORD_W +: COORD_W] = (ca > cb) ? ca : cb;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_rebuild    <= 1'b0;
            pend_rebuild    <= 1'b0;
            pend_refit      <= 1'b0;
            idx             <= '0;
            cnt             <= '0;
            left            <= '0;
            build_req       <= 1'b0;
            mem.rd_req      <= 1'b0;
            mem.rd_addr     <= '0;
            mem.wr_valid    <= 1'b0;
            mem.wr_addr     <= '0;
            mem.wr_data     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            job_was_rebuild <= 1'b0;
            nodes_refit     <= '0;
        end else begin
            done <= 1'b0;

            // One-deep pending per kind; a pending rebuild subsumes any refit.
            if (state != IDLE) begin
                if (start_rebuild) begin
                    pend_rebuild <= 1'b1;
                    pend_refit   <= 1'b0;
                end else if (start_refit && !pend_rebuild) begin
                    pend_refit <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_rebuild || pend_rebuild) begin
                        state        <= BREQ;
                        mode_rebuild <= 1'b1;
                        build_req    <= 1'b1;
                        busy         <= 1'b1;
                        pend_rebuild <= 1'b0;
                        pend_refit   <= 1'b0;
                    end else if (start_refit || pend_refit) begin
                        state        <= RINIT;
                        mode_rebuild <= 1'b0;
                        busy         <= 1'b1;
                        pend_refit   <= 1'b0;
                    end
                end
                BREQ: begin
                    if (build_ack) begin
                        build_req <= 1'b0;
                        state     <= BWAIT;
                    end
                end
                BWAIT: begin
                    if (build_done) state <= RINIT;
                end
                RINIT: begin
                    cnt <= '0;
                    if (num_internal == '0) begin
                        state <= DONE;
                    end else begin
                        idx         <= n_m1;
                        mem.rd_req  <= 1'b1;
                        mem.rd_addr <= {n_m1, 1'b1};
                        state       <= RDL;
                    end
                end
                RDL: begin
                    if (mem.rd_ready) begin
                        mem.rd_req <= 1'b0;
                        state      <= WTL;
                    end
                end
                WTL: begin
                    if (mem.rd_valid) begin
                        left        <= mem.rd_data;
                        mem.rd_req  <= 1'b1;
                        mem.rd_addr <= {idx, 1'b0} + ADDR_W'(2);
                        state       <= RDR;
                    end
                end
                RDR: begin
                    if (mem.rd_ready) begin
                        mem.rd_req <= 1'b0;
                        state      <= WTR;
                    end
                end
                WTR: begin
                    // Right child is merged straight off the read bus.
                    if (mem.rd_valid) begin
                        mem.wr_valid <= 1'b1;
                        mem.wr_addr  <= ADDR_W'(idx);
                        mem.wr_data  <= merge(left, mem.rd_data);
                        state        <= WR;
                    end
                end
                WR: begin
                    if (mem.wr_ready) begin
                        mem.wr_valid <= 1'b0;
                        cnt          <= cnt + NODE_W'(1);
                        if (idx == '0) begin
                            state <= DONE;
                        end else begin
                            idx         <= idx_m1;
                            mem.rd_req  <= 1'b1;
                            mem.rd_addr <= {idx_m1, 1'b1};
                            state       <= RDL;
                        end
                    end
                end
                DONE: begin
                    done            <= 1'b1;
                    busy            <= 1'b0;
                    nodes_refit     <= cnt;
                    job_was_rebuild <= mode_rebuild;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bvh_update_engine.sv
// Directed bench for bvh_update_engine: node-memory responder, builder responder
// and hand-computed bounds for small trees.
module tb_bvh_update_engine;
    localparam int NW = 12;
    localparam int AW = 13;
    localparam int CW = 16;
    localparam int BW = 6 * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_rebuild = 1'b0;
    logic          start_refit = 1'b0;
    logic [NW-1:0] num_internal = '0;
    logic          build_req;
    logic          build_ack = 1'b0;
    logic          build_done = 1'b0;
    logic          busy;
    logic          done;
    logic          job_was_rebuild;
    logic [NW-1:0] nodes_refit;

    bvh_update_engine_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

    bvh_update_engine #(.NODE_W(NW), .ADDR_W(AW), .COORD_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_rebuild   (start_rebuild),
        .start_refit     (start_refit),
        .num_internal    (num_internal),
        .build_req       (build_req),
        .build_ack       (build_ack),
        .build_done      (build_done),
        .mem             (bus),
        .busy            (busy),
        .done            (done),
        .job_was_rebuild (job_was_rebuild),
        .nodes_refit     (nodes_refit)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5);
        return {16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    logic [BW-1:0] mem [0:63];

    // Node-memory responder
    bit            mem_en = 1'b0;
    bit            bp = 1'b0;
    bit            building = 1'b0;
    bit            rd_pend = 1'b0;
    int            rd_wait = 0;
    logic [AW-1:0] rd_pend_addr;
    bit            rd_stall = 1'b0;
    bit            wr_stall = 1'b0;
    logic [AW-1:0] rd_hold_addr;
    logic [AW-1:0] wr_hold_addr;
    logic [BW-1:0] wr_hold_data;
    int            n_reads = 0;
    int            n_writes = 0;
    int            reads_in_build = 0;
    int            wr_log[$];

    initial begin
        bus.rd_ready = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        bus.wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!mem_en) begin
                rd_pend  = 1'b0;
                rd_stall = 1'b0;
                wr_stall = 1'b0;
            end else begin
                bus.rd_valid = 1'b0;
                if (rd_pend) begin
                    if (rd_wait == 0) begin
                        bus.rd_valid = 1'b1;
                        bus.rd_data  = mem[rd_pend_addr[5:0]];
                        rd_pend      = 1'b0;
                    end else begin
                        rd_wait--;
                    end
                end
                if (rd_stall) begin
                    chk("rd_hold_req", BW'(bus.rd_req), BW'(1));
                    chk("rd_hold_addr", BW'(bus.rd_addr), BW'(rd_hold_addr));
                end
                if (wr_stall) begin
                    chk("wr_hold_valid", BW'(bus.wr_valid), BW'(1));
                    chk("wr_hold_addr", BW'(bus.wr_addr), BW'(wr_hold_addr));
                    chk("wr_hold_data", bus.wr_data, wr_hold_data);
                end
                bus.rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                rd_stall     = bus.rd_req && !bus.rd_ready;
                wr_stall     = bus.wr_valid && !bus.wr_ready;
                rd_hold_addr = bus.rd_addr;
                wr_hold_addr = bus.wr_addr;
                wr_hold_data = bus.wr_data;
                if (bus.rd_req && bus.rd_ready) begin
                    rd_pend      = 1'b1;
                    rd_pend_addr = bus.rd_addr;
                    rd_wait      = bp ? int'($urandom_range(0, 5)) : 0;
                    n_reads++;
                    if (building) reads_in_build++;
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    mem[bus.wr_addr[5:0]] = bus.wr_data;
                    wr_log.push_back(int'(bus.wr_addr));
                    n_writes++;
                end
            end
        end
    end

    // Builder responder: ack after ack_delay cycles of build_req, done pulse after done_delay
    int ack_delay = 3;
    int done_delay = 10;
    int b_st = 0;
    int b_cnt = 0;
    int d_cnt = 0;
    int n_builds = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_st = 0; b_cnt = 0; build_ack = 1'b0; build_done = 1'b0; building = 1'b0;
            end else begin
                case (b_st)
                    0: begin
                        if (b_cnt != 0) chk("breq_hold", BW'(build_req), BW'(1));
                        if (build_req) begin
                            if (b_cnt == 0) n_builds++;
                            b_cnt++;
                            building = 1'b1;
                            if (b_cnt == ack_delay) begin
                                build_ack = 1'b1;
                                b_st = 1;
                            end
                        end
                    end
                    1: begin
                        build_ack = 1'b0;
                        chk("breq_drop", BW'(build_req), BW'(0));
                        d_cnt = 0;
                        b_st = 2;
                    end
                    2: begin
                        d_cnt++;
                        if (d_cnt == done_delay) begin
                            build_done = 1'b1;
                            b_st = 3;
                        end
                    end
                    default: begin
                        build_done = 1'b0;
                        b_cnt = 0;
                        building = 1'b0;
                        b_st = 0;
                    end
                endcase
            end
        end
    end

    // Completion monitor
    int n_done = 0;
    bit prev_done = 1'b0;
    int jq_wbr[$];
    int jq_nr[$];

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                jq_wbr.push_back(int'(job_was_rebuild));
                jq_nr.push_back(int'(nodes_refit));
                chk("busy_at_done", BW'(busy), BW'(0));
                chk("done_width", BW'(prev_done), BW'(0));
            end
            prev_done = done;
        end
    end

    function automatic int wlog(input int i);
        return (i < wr_log.size()) ? wr_log[i] : -1;
    endfunction

    function automatic int job_wbr(input int i);
        return (i < jq_wbr.size()) ? jq_wbr[i] : -1;
    endfunction

    function automatic int job_nr(input int i);
        return (i < jq_nr.size()) ? jq_nr[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit rb, input bit rf, input int n);
        num_internal  = NW'(n);
        start_rebuild = rb;
        start_refit   = rf;
        @(negedge clk);
        start_rebuild = 1'b0;
        start_refit   = 1'b0;
    endtask

    task automatic wait_jobs(input int target, input int maxc, input string tag);
        int c;
        c = 0;
        while (n_done < target && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk(tag, BW'(n_done), BW'(target));
    endtask

    task automatic init_tree();
        mem[0] = '0; mem[1] = '0; mem[2] = '0;
        mem[3] = pk(-5, 10, 0, 3, 20, 7);
        mem[4] = pk(2, -8, 1, 9, 12, 4);
        mem[5] = pk(-32768, 5, 5, -1, 6, 30);
        mem[6] = pk(100, -3, -2, 200, 0, 2);
        wr_log.delete();
    endtask

    task automatic check_tree(input string tag);
        chk({tag, "_n2"}, mem[2], pk(-32768, -3, -2, 200, 6, 30));
        chk({tag, "_n1"}, mem[1], pk(-5, -8, 0, 9, 20, 7));
        chk({tag, "_n0"}, mem[0], pk(-32768, -8, -2, 200, 20, 30));
    endtask

    initial begin
        int nb0, nr0, nw0, c;

        #1;
        chk("rst_flags", BW'({busy, done, build_req, bus.rd_req, bus.wr_valid, job_was_rebuild}), BW'(0));
        chk("rst_nodes_refit", BW'(nodes_refit), BW'(0));
        tick(3);
        rst_n  = 1'b1;
        mem_en = 1'b1;
        tick(2);

        // Plain refit, N=3
        init_tree();
        pulse(1'b0, 1'b1, 3);
        wait_jobs(1, 200, "t1_done");
        chk("t1_nwr", BW'(wr_log.size()), BW'(3));
        chk("t1_wr0", BW'(wlog(0)), BW'(2));
        chk("t1_wr1", BW'(wlog(1)), BW'(1));
        chk("t1_wr2", BW'(wlog(2)), BW'(0));
        check_tree("t1");
        chk("t1_nr", BW'(job_nr(0)), BW'(3));
        chk("t1_wbr", BW'(job_wbr(0)), BW'(0));

        // Rebuild: builder handoff, then refit
        init_tree();
        nb0 = n_builds;
        pulse(1'b1, 1'b0, 3);
        wait_jobs(2, 300, "t2_done");
        chk("t2_builds", BW'(n_builds - nb0), BW'(1));
        chk("t2_rd_in_build", BW'(reads_in_build), BW'(0));
        check_tree("t2");
        chk("t2_nr", BW'(job_nr(1)), BW'(3));
        chk("t2_wbr", BW'(job_wbr(1)), BW'(1));

        // N=0: done three cycles after start, no memory traffic
        nr0 = n_reads;
        nw0 = n_writes;
        num_internal = '0;
        start_refit = 1'b1;
        @(negedge clk);
        start_refit = 1'b0;
        chk("t3_busy1", BW'(busy), BW'(1));
        chk("t3_done1", BW'(done), BW'(0));
        @(negedge clk);
        chk("t3_done2", BW'(done), BW'(0));
        @(negedge clk);
        chk("t3_done3", BW'(done), BW'(1));
        tick(2);
        chk("t3_reads", BW'(n_reads - nr0), BW'(0));
        chk("t3_writes", BW'(n_writes - nw0), BW'(0));
        chk("t3_nr", BW'(job_nr(2)), BW'(0));
        chk("t3_wbr", BW'(job_wbr(2)), BW'(0));

        // Random backpressure and read latency
        init_tree();
        bp = 1'b1;
        pulse(1'b0, 1'b1, 3);
        wait_jobs(4, 2000, "t4_done");
        bp = 1'b0;
        tick(2);
        check_tree("t4");
        chk("t4_nr", BW'(job_nr(3)), BW'(3));

        // Starts while busy: two refits then a rebuild coalesce into one rebuild
        init_tree();
        nb0 = n_builds;
        pulse(1'b0, 1'b1, 3);
        tick(2);
        pulse(1'b0, 1'b1, 3);
        tick(1);
        pulse(1'b0, 1'b1, 3);
        tick(1);
        pulse(1'b1, 1'b0, 3);
        wait_jobs(6, 500, "t5_done");
        tick(100);
        chk("t5_no_extra", BW'(n_done), BW'(6));
        chk("t5_wbr_a", BW'(job_wbr(4)), BW'(0));
        chk("t5_wbr_b", BW'(job_wbr(5)), BW'(1));
        chk("t5_builds", BW'(n_builds - nb0), BW'(1));
        check_tree("t5");

        // Coincident starts in IDLE: rebuild only
        pulse(1'b1, 1'b1, 3);
        wait_jobs(7, 500, "t6_done");
        tick(100);
        chk("t6_no_extra", BW'(n_done), BW'(7));
        chk("t6_wbr", BW'(job_wbr(6)), BW'(1));
        chk("t6_builds", BW'(n_builds - nb0), BW'(2));

        // Signed merge, N=1
        mem[0] = '0;
        mem[1] = pk(-5, -32768, 32767, -5, -32768, 32767);
        mem[2] = pk(3, 32767, -32768, 3, 32767, -32768);
        pulse(1'b0, 1'b1, 1);
        wait_jobs(8, 200, "t7_done");
        chk("t7_merge", mem[0], pk(-5, -32768, -32768, 3, 32767, 32767));
        chk("t7_nr", BW'(job_nr(7)), BW'(1));

        // Reset while waiting for the right-child read data
        mem_en = 1'b0;
        tick(1);
        bus.rd_ready = 1'b1;
        bus.wr_ready = 1'b1;
        bus.rd_valid = 1'b0;
        init_tree();
        pulse(1'b0, 1'b1, 3);
        c = 0;
        while (!bus.rd_req && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t8_rd1_addr", BW'(bus.rd_addr), BW'(5));
        @(negedge clk);
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem[5];
        @(negedge clk);
        bus.rd_valid = 1'b0;
        chk("t8_rd2_req", BW'(bus.rd_req), BW'(1));
        chk("t8_rd2_addr", BW'(bus.rd_addr), BW'(6));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_flags", BW'({busy, done, build_req, bus.rd_req, bus.wr_valid, job_was_rebuild}), BW'(0));
        chk("t8_rst_nr", BW'(nodes_refit), BW'(0));
        chk("t8_rst_addr", BW'(bus.rd_addr), BW'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t8_idle_busy", BW'(busy), BW'(0));
        bus.rd_ready = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_data  = '1;
        pulse(1'b0, 1'b1, 3);
        @(negedge clk);
        bus.rd_valid = 1'b0;
        wr_log.delete();
        mem_en = 1'b1;
        wait_jobs(9, 300, "t8_done");
        check_tree("t8");
        chk("t8_nr", BW'(job_nr(8)), BW'(3));
        chk("t8_nwr", BW'(wr_log.size()), BW'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
